game_soc_spi_slave: RTL and testbench
=====================================

GAME_SOC_SPI_SLAVE -- requirements
Module: game_soc_spi_slave

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: flops in each SCLK/SS_n/MOSI synchronizer.
REQ-002 SHALL have parameter DATABITS, default 8: frame length in bits; MSB first; SPI mode 0 (CPOL=0, CPHA=0).
REQ-003 clk  in  1  system clock, 50 MHz.
REQ-004 reset_n  in  1  reset; asynchronous, active-low.
REQ-005 spi_select  in  1  register-port chip select.
REQ-006 mem_addr  in  3  register address.
REQ-007 read_n / write_n  in  1 each  active-low strobes.
REQ-008 data_from_cpu  in  16  write data.
REQ-009 data_to_cpu  out  16  registered read data.
REQ-010 irq  out  1  registered interrupt.
REQ-011 SCLK, SS_n, MOSI  in  1 each  SPI bus from an external master; asynchronous to clk.
REQ-012 MISO  out  1  serial data to the master.
REQ-013 MISO_oe  out  1  MISO drive enable, equal to ~SS_n after synchronization.

Function
REQ-014 Registers: 0 rxdata (r), 1 txdata (w), 2 status (r; any write clears ROE/TUE/TOE), 3 control (r/w).
REQ-015 Status layout: bit3 ROE, bit4 TOE, bit5 TUE, bit6 TRDY, bit7 RRDY, bit8 E = ROE|TOE|TUE.
REQ-016 Control layout: bits 3..8 are IRQ enables, aligned to the matching status bits; all other bits read 0.
REQ-017 Accesses SHALL take two cycles; a register write SHALL act in the cycle after strobe assertion, and data_to_cpu SHALL be valid one cycle after the read strobe.
REQ-018 SCLK, SS_n and MOSI SHALL pass through SYNC_STAGES flops before use; SCLK edges SHALL be detected from the last two synchronized samples.
REQ-019 Supported SCLK SHALL be at most clk/8.
REQ-020 Synced SS_n falling edge: bit counter SHALL clear to 0. The shift register SHALL load tx_holding if it is primed; primed SHALL then clear.
REQ-021 If tx_holding is not primed at that load, the shift register SHALL load 0x00 and TUE SHALL set.
REQ-022 MISO SHALL equal shift_reg[DATABITS-1].
REQ-023 On each synced SCLK rising edge: MOSI SHALL be sampled into rx_shift LSB and the counter SHALL increment.
REQ-024 On the DATABITS-th rising edge: rx_holding SHALL load the full byte, RRDY SHALL set, ROE SHALL set if RRDY was already 1, and the counter SHALL wrap to 0.
REQ-025 On a synced SCLK falling edge with counter != 0: shift_reg SHALL shift left by one.
REQ-026 On a falling edge with counter == 0 and a frame already received: shift_reg SHALL reload, using the REQ-020/021 rules, for back-to-back frames.
REQ-027 TRDY SHALL equal ~tx_primed. A txdata write while TRDY=0 SHALL set TOE and SHALL leave tx_holding unchanged.
REQ-028 Reading rxdata SHALL clear RRDY. If RRDY is set in the same cycle, the set SHALL win.
REQ-029 Synced SS_n rising mid-frame: the partial byte SHALL be discarded and the counter SHALL clear. RRDY SHALL NOT set; tx_primed SHALL be unchanged.
REQ-030 SCLK edges while synced SS_n is high SHALL be ignored.
REQ-031 irq SHALL be registered: OR over status bits AND their enables.

Reset
REQ-032 All flops SHALL reset asynchronously on reset_n low.
REQ-033 Reset values: data_to_cpu=0, irq=0, MISO=0, MISO_oe=0, all status and control bits 0, holding and shift registers 0.
REQ-034 Synchronizer outputs SHALL reset to the idle bus state: SCLK 0, SS_n 1.

Structure
REQ-035 Register addresses, status/control bit positions and DATABITS SHALL live in a shared package game_soc_spi_pkg, shared with the SPI master.
REQ-036 The synchronizer SHALL be one sub-module, game_soc_spi_sync, instantiated once per input, with SYNC_STAGES as a parameter.
REQ-037 Target size 150-300 lines RTL.

Verification
REQ-038 Write txdata 0xA5, master sends 0x3C at clk/8 -> MISO bits 1,0,1,0,0,1,0,1; rxdata=0x3C; RRDY=1; TRDY=1.
REQ-039 Two frames with no txdata write -> second frame shifts out 0x00; TUE=1; irq=1 when bit5 is enabled.
REQ-040 Two frames received without reading rxdata -> ROE=1; rxdata=second byte; status write -> ROE=0.
REQ-041 txdata write twice before any frame -> TOE=1; 0x11 (the first value) is transmitted.
REQ-042 SS_n deasserted after 4 bits, then a full frame 0x81 -> rxdata=0x81; RRDY set exactly once.
REQ-043 reset_n asserted mid-frame -> all outputs at reset values within 1 cycle; the next full frame is received correctly.

Source files
------------

// File: rtl/game_soc_spi_pkg.sv
// game_soc_spi_pkg
// Definitions shared by the SPI slave and the SPI master: register map,
// status/control bit positions, default frame length and a helper that
// places the status flags into their 16-bit register positions.
// No ports.
package game_soc_spi_pkg;

    localparam int SPI_DATABITS = 8;

    localparam logic [2:0] ADDR_RXDATA  = 3'd0;
    localparam logic [2:0] ADDR_TXDATA  = 3'd1;
    localparam logic [2:0] ADDR_STATUS  = 3'd2;
    localparam logic [2:0] ADDR_CONTROL = 3'd3;

    localparam int ST_ROE  = 3;
    localparam int ST_TOE  = 4;
    localparam int ST_TUE  = 5;
    localparam int ST_TRDY = 6;
    localparam int ST_RRDY = 7;
    localparam int ST_E    = 8;

    // Field order matches bits 8..3 of the status and control registers.
    typedef struct packed {
        logic e;
        logic rrdy;
        logic trdy;
        logic tue;
        logic toe;
        logic roe;
    } spi_status_t;

    function automatic logic [15:0] status_word(input spi_status_t s);
        return {7'b0, s, 3'b0};
    endfunction

endpackage

// File: rtl/game_soc_spi_sync.sv
// game_soc_spi_sync
// Multi-flop synchronizer for one asynchronous input bit.
// Ports:
//   clk, reset_n   system clock, asynchronous active-low reset
//   i_d            asynchronous input
//   o_q            synchronized output (resets to RESET_VAL)
module game_soc_spi_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= {STAGES{RESET_VAL}};
        end else begin
            r_sync[0] <= i_d;
            for (int i = 1; i < STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/game_soc_spi_slave.sv
// game_soc_spi_slave
// SPI mode-0 slave with a CPU register port (rxdata/txdata/status/control).
// Ports:
//   clk, reset_n                 system clock, asynchronous active-low reset
//   spi_select, mem_addr,
//   read_n, write_n,
//   data_from_cpu, data_to_cpu   two-cycle register port, registered read data
//   irq                          registered OR of enabled status bits
//   SCLK, SS_n, MOSI             SPI bus from the external master (async)
//   MISO, MISO_oe                serial data out and its drive enable
module game_soc_spi_slave
    import game_soc_spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DATABITS    = SPI_DATABITS
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        spi_select,
    input  logic [2:0]  mem_addr,
    input  logic        read_n,
    input  logic        write_n,
    input  logic [15:0] data_from_cpu,
    output logic [15:0] data_to_cpu,
    output logic        irq,
    input  logic        SCLK,
    input  logic        SS_n,
    input  logic        MOSI,
    output logic        MISO,
    output logic        MISO_oe
);

    localparam int CW = (DATABITS > 2) ? $clog2(DATABITS) : 1;

    // ---------------- bus synchronizers ----------------
    logic w_sclk, w_ss_n, w_mosi;

    game_soc_spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .reset_n(reset_n), .i_d(SCLK), .o_q(w_sclk));
    game_soc_spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
        .clk(clk), .reset_n(reset_n), .i_d(SS_n), .o_q(w_ss_n));
    game_soc_spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .reset_n(reset_n), .i_d(MOSI), .o_q(w_mosi));

    // ---------------- state ----------------
    logic                r_sclk_prev, r_ss_prev;
    logic [CW-1:0]       r_cnt;
    logic [DATABITS-1:0] r_rx_shift, r_rx_hold, r_shift, r_tx_hold;
    logic                r_tx_primed, r_frame_done;
    logic                r_roe, r_toe, r_tue, r_rrdy;
    logic [5:0]          r_ctrl;
    logic                r_wr_d, r_wr_d2, r_rd_d;
    logic [2:0]          r_waddr;
    logic [15:0]         r_wdata;

    // ---------------- edge detection ----------------
    logic w_sclk_rise, w_sclk_fall, w_ss_fall, w_ss_rise, w_in_frame;

    assign w_sclk_rise = w_sclk & ~r_sclk_prev;
    assign w_sclk_fall = ~w_sclk & r_sclk_prev;
    assign w_ss_fall   = ~w_ss_n & r_ss_prev;
    assign w_ss_rise   = w_ss_n & ~r_ss_prev;
    // Selected and not on the select edge itself: SCLK edges count only here.
    assign w_in_frame  = ~w_ss_n & ~r_ss_prev;

    logic                w_last_bit, w_load, w_shift;
    logic [DATABITS-1:0] w_rx_next;

    assign w_last_bit = (r_cnt == CW'(DATABITS - 1));
    assign w_rx_next  = {r_rx_shift[DATABITS-2:0], w_mosi};
    // Load at select, and again on the falling edge that ends each frame so
    // a back-to-back frame has its first bit on MISO before its first rise.
    assign w_load  = w_ss_fall |
                     (w_in_frame & w_sclk_fall & (r_cnt == '0) & r_frame_done);
    assign w_shift = w_in_frame & w_sclk_fall & (r_cnt != '0);

    // ---------------- CPU port strobes ----------------
    logic w_wr, w_rd, w_wr_first, w_wr_act, w_rd_first;

    assign w_wr       = spi_select & ~write_n;
    assign w_rd       = spi_select & ~read_n;
    assign w_wr_first = w_wr & ~r_wr_d;
    // Write takes effect one cycle after the strobe, once per access.
    assign w_wr_act   = r_wr_d & ~r_wr_d2;
    assign w_rd_first = w_rd & ~r_rd_d;

    // ---------------- status / read mux ----------------
    spi_status_t w_status;
    logic [5:0]  w_stat_bits;
    logic [15:0] w_rdata;
    logic        w_unused;

    assign w_status    = {r_roe | r_toe | r_tue, r_rrdy, ~r_tx_primed,
                          r_tue, r_toe, r_roe};
    assign w_stat_bits = w_status;
    assign w_unused    = ^r_wdata;

    always_comb begin
        w_rdata = '0;
        case (mem_addr)
            ADDR_RXDATA:  w_rdata[DATABITS-1:0] = r_rx_hold;
            ADDR_STATUS:  w_rdata = status_word(w_status);
            ADDR_CONTROL: w_rdata = {7'b0, r_ctrl, 3'b0};
            default:      w_rdata = '0;
        endcase
    end

    // ---------------- sequential ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sclk_prev  <= 1'b0;
            r_ss_prev    <= 1'b1;
            r_cnt        <= '0;
            r_rx_shift   <= '0;
            r_rx_hold    <= '0;
            r_shift      <= '0;
            r_tx_hold    <= '0;
            r_tx_primed  <= 1'b0;
            r_frame_done <= 1'b0;
            r_roe        <= 1'b0;
            r_toe        <= 1'b0;
            r_tue        <= 1'b0;
            r_rrdy       <= 1'b0;
            r_ctrl       <= '0;
            r_wr_d       <= 1'b0;
            r_wr_d2      <= 1'b0;
            r_rd_d       <= 1'b0;
            r_waddr      <= '0;
            r_wdata      <= '0;
            data_to_cpu  <= '0;
            irq          <= 1'b0;
        end else begin
            r_sclk_prev <= w_sclk;
            r_ss_prev   <= w_ss_n;
            r_wr_d      <= w_wr;
            r_wr_d2     <= r_wr_d;
            r_rd_d      <= w_rd;
            irq         <= |(w_stat_bits & r_ctrl);

            if (w_wr_first) begin
                r_waddr <= mem_addr;
                r_wdata <= data_from_cpu;
            end
            if (w_rd) data_to_cpu <= w_rdata;

            // CPU side first so that same-cycle SPI sets override clears.
            if (w_wr_act) begin
                case (r_waddr)
                    ADDR_TXDATA: begin
                        if (r_tx_primed) begin
                            r_toe <= 1'b1;
                        end else begin
                            r_tx_hold   <= r_wdata[DATABITS-1:0];
                            r_tx_primed <= 1'b1;
                        end
                    end
                    ADDR_STATUS: begin
                        r_roe <= 1'b0;
                        r_toe <= 1'b0;
                        r_tue <= 1'b0;
                    end
                    ADDR_CONTROL: r_ctrl <= r_wdata[ST_E:ST_ROE];
                    default: ;
                endcase
            end
            if (w_rd_first && mem_addr == ADDR_RXDATA) r_rrdy <= 1'b0;

            // Transmit side
            if (w_load) begin
                if (r_tx_primed) begin
                    r_shift     <= r_tx_hold;
                    r_tx_primed <= 1'b0;
                end else begin
                    r_shift <= '0;
                    r_tue   <= 1'b1;
                end
            end else if (w_shift) begin
                r_shift <= {r_shift[DATABITS-2:0], 1'b0};
            end

            // Receive side
            if (w_ss_fall) begin
                r_cnt        <= '0;
                r_frame_done <= 1'b0;
            end else if (w_ss_rise) begin
                r_cnt        <= '0;
                r_rx_shift   <= '0;
                r_frame_done <= 1'b0;
            end else if (w_in_frame && w_sclk_rise) begin
                r_rx_shift <= w_rx_next;
                if (w_last_bit) begin
                    r_cnt        <= '0;
                    r_rx_hold    <= w_rx_next;
                    r_rrdy       <= 1'b1;
                    r_frame_done <= 1'b1;
                    if (r_rrdy) r_roe <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

    assign MISO    = r_shift[DATABITS-1];
    assign MISO_oe = ~w_ss_n;

endmodule

// File: tb/tb_game_soc_spi_slave.sv
// Testbench for game_soc_spi_slave: directed SPI frames and register
// accesses. Expected read data and MISO bits are queued by the stimulus and
// checked by independent monitor processes.
module tb_game_soc_spi_slave;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        spi_select;
    logic [2:0]  mem_addr;
    logic        read_n, write_n;
    logic [15:0] data_from_cpu;
    logic [15:0] data_to_cpu;
    logic        irq;
    logic        SCLK, SS_n, MOSI;
    logic        MISO, MISO_oe;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       name;
        logic [15:0] val;
    } rd_exp_t;

    rd_exp_t rdq[$];
    logic    mq[$];
    logic    rd_prev = 1'b0;

    game_soc_spi_slave #(.SYNC_STAGES(2), .DATABITS(8)) dut (
        .clk(clk), .reset_n(reset_n), .spi_select(spi_select),
        .mem_addr(mem_addr), .read_n(read_n), .write_n(write_n),
        .data_from_cpu(data_from_cpu), .data_to_cpu(data_to_cpu), .irq(irq),
        .SCLK(SCLK), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO), .MISO_oe(MISO_oe));

    always #10 clk = ~clk;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Read-data monitor: data_to_cpu is valid the cycle after the read strobe.
    initial begin
        forever begin
            @(posedge clk);
            if (spi_select && !read_n && !rd_prev) begin
                rd_prev = 1'b1;
                @(negedge clk);
                checks++;
                if (rdq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_read: got %h expected none", data_to_cpu);
                end else begin
                    rd_exp_t e;
                    e = rdq.pop_front();
                    if (data_to_cpu !== e.val) begin
                        errors++;
                        $display("FAIL %s: got %h expected %h", e.name, data_to_cpu, e.val);
                    end
                end
            end else begin
                rd_prev = spi_select && !read_n;
            end
        end
    end

    // MISO monitor: the master samples MISO on each SCLK rising edge.
    initial begin
        forever begin
            @(posedge SCLK);
            if (!SS_n) begin
                checks++;
                if (mq.size() == 0) begin
                    errors++;
                    $display("FAIL miso_unexpected: got %b expected none", MISO);
                end else begin
                    logic b;
                    b = mq.pop_front();
                    if (MISO !== b) begin
                        errors++;
                        $display("FAIL miso_bit: got %b expected %b", MISO, b);
                    end
                end
            end
        end
    end

    task automatic cpu_wr(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        spi_select = 1'b1; write_n = 1'b0; mem_addr = a; data_from_cpu = d;
        @(negedge clk);
        @(negedge clk);
        spi_select = 1'b0; write_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic cpu_rd(input logic [2:0] a, input logic [15:0] exp, input string name);
        rd_exp_t e;
        e.name = name;
        e.val  = exp;
        rdq.push_back(e);
        @(negedge clk);
        spi_select = 1'b1; read_n = 1'b0; mem_addr = a;
        @(negedge clk);
        @(negedge clk);
        spi_select = 1'b0; read_n = 1'b1;
        @(negedge clk);
    endtask

    // Mode-0 master at clk/8: MOSI changes on the falling edge.
    task automatic spi_frame(input logic [7:0] tx, input logic [7:0] exp_miso,
                             input int nbits, input bit release_ss);
        logic [7:0] sh;
        logic [7:0] em;
        sh = tx;
        em = exp_miso;
        @(negedge clk);
        SS_n = 1'b0;
        MOSI = sh[7];
        repeat (8) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            mq.push_back(em[7]);
            em = em << 1;
            SCLK = 1'b1;
            repeat (4) @(negedge clk);
            SCLK = 1'b0;
            sh = sh << 1;
            MOSI = sh[7];
            repeat (4) @(negedge clk);
        end
        if (release_ss) begin
            SS_n = 1'b1;
            repeat (8) @(negedge clk);
        end
    endtask

    initial begin
        reset_n = 1'b0; spi_select = 1'b0; mem_addr = '0;
        read_n = 1'b1; write_n = 1'b1; data_from_cpu = '0;
        SCLK = 1'b0; SS_n = 1'b1; MOSI = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_data_to_cpu", data_to_cpu, 16'h0000);
        chk("rst_irq", {15'b0, irq}, 16'h0000);
        chk("rst_miso", {15'b0, MISO}, 16'h0000);
        chk("rst_miso_oe", {15'b0, MISO_oe}, 16'h0000);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        // TRDY is ~tx_primed, so it reads 1 out of reset.
        cpu_rd(3'd2, 16'h0040, "rst_status");
        cpu_rd(3'd3, 16'h0000, "rst_control");

        // Basic transfer: tx 0xA5, rx 0x3C.
        cpu_wr(3'd1, 16'h00A5);
        cpu_rd(3'd2, 16'h0000, "t1_status_primed");
        spi_frame(8'h3C, 8'hA5, 8, 1'b1);
        chk("t1_miso_oe_idle", {15'b0, MISO_oe}, 16'h0000);
        cpu_rd(3'd2, 16'h01E0, "t1_status_after");
        cpu_rd(3'd0, 16'h003C, "t1_rxdata");
        cpu_rd(3'd2, 16'h0160, "t1_status_rrdy_clr");
        cpu_wr(3'd2, 16'h0000);
        cpu_rd(3'd2, 16'h0040, "t1_status_cleared");

        // Underrun and overrun: two frames, no txdata, no rxdata read.
        cpu_wr(3'd3, 16'h0020);
        cpu_rd(3'd3, 16'h0020, "t2_control");
        repeat (2) @(negedge clk);
        chk("t2_irq_idle", {15'b0, irq}, 16'h0000);
        spi_frame(8'h12, 8'h00, 8, 1'b1);
        spi_frame(8'h34, 8'h00, 8, 1'b1);
        cpu_rd(3'd2, 16'h01E8, "t2_status_roe_tue");
        chk("t2_irq_tue", {15'b0, irq}, 16'h0001);
        cpu_rd(3'd0, 16'h0034, "t2_rxdata_second");
        cpu_wr(3'd2, 16'h0000);
        cpu_rd(3'd2, 16'h0040, "t2_status_cleared");
        repeat (2) @(negedge clk);
        chk("t2_irq_cleared", {15'b0, irq}, 16'h0000);
        cpu_wr(3'd3, 16'h0000);

        // Transmit overrun: second txdata write is dropped.
        cpu_wr(3'd1, 16'h0011);
        cpu_wr(3'd1, 16'h0022);
        cpu_rd(3'd2, 16'h0110, "t3_status_toe");
        spi_frame(8'hC3, 8'h11, 8, 1'b1);
        cpu_rd(3'd2, 16'h01F0, "t3_status_after");
        cpu_rd(3'd0, 16'h00C3, "t3_rxdata");
        cpu_wr(3'd2, 16'h0000);
        cpu_rd(3'd2, 16'h0040, "t3_status_cleared");

        // Aborted partial frame followed by a full frame.
        spi_frame(8'hF0, 8'h00, 4, 1'b1);
        cpu_rd(3'd2, 16'h0160, "t4_status_partial");
        spi_frame(8'h81, 8'h00, 8, 1'b1);
        cpu_rd(3'd2, 16'h01E0, "t4_status_full");
        cpu_rd(3'd0, 16'h0081, "t4_rxdata");
        cpu_rd(3'd2, 16'h0160, "t4_status_rrdy_clr");
        cpu_wr(3'd2, 16'h0000);

        // Reset in the middle of a frame.
        cpu_wr(3'd3, 16'h0040);
        cpu_wr(3'd1, 16'h00FF);
        spi_frame(8'hFF, 8'hFF, 4, 1'b0);
        chk("t5_pre_irq", {15'b0, irq}, 16'h0001);
        chk("t5_pre_miso", {15'b0, MISO}, 16'h0001);
        chk("t5_pre_miso_oe", {15'b0, MISO_oe}, 16'h0001);
        chk("t5_pre_data", data_to_cpu, 16'h0160);
        reset_n = 1'b0;
        #1;
        chk("t5_rst_data", data_to_cpu, 16'h0000);
        chk("t5_rst_irq", {15'b0, irq}, 16'h0000);
        chk("t5_rst_miso", {15'b0, MISO}, 16'h0000);
        chk("t5_rst_miso_oe", {15'b0, MISO_oe}, 16'h0000);
        @(negedge clk);
        SS_n = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        cpu_rd(3'd3, 16'h0000, "t5_control_reset");
        cpu_wr(3'd1, 16'h0069);
        spi_frame(8'hA7, 8'h69, 8, 1'b1);
        cpu_rd(3'd2, 16'h01E0, "t5_status_after");
        cpu_rd(3'd0, 16'h00A7, "t5_rxdata");

        repeat (20) @(negedge clk);
        if (rdq.size() != 0 || mq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d reads %0d bits pending expected 0", rdq.size(), mq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
